// File: rtl/alu_cmd_pipe_if.sv
// -----------------------------------------------------------------------------
// alu_cmd_pipe_if
//
// Purpose:
//   Bundles every handshake and data signal of alu_cmd_pipe so the block and
//   its environment connect through one port. Three groups live here:
//     - command input  : in_valid/in_ready handshake carrying in_op/in_a/in_b
//     - ALU side bus   : alu_a/alu_b/alu_op out to a combinational 4-bit ALU,
//                        alu_result/alu_carry back from it
//     - result output  : out_valid/out_ready handshake carrying out_result,
//                        out_carry, out_zero, out_op
//   plus the FIFO occupancy count.
//
// Modports:
//   slave  : the alu_cmd_pipe side.
//   master : the environment side (command producer, ALU and result consumer).
//
// Parameters:
//   DEPTH  : FIFO entries; must match the DEPTH of the attached alu_cmd_pipe.
// -----------------------------------------------------------------------------
interface alu_cmd_pipe_if #(
   parameter int DEPTH = 4
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   // command input handshake
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       in_a;
   logic [3:0]       in_b;
   logic [2:0]       in_op;

   // combinational ALU bus
   logic [3:0]       alu_a;
   logic [3:0]       alu_b;
   logic [2:0]       alu_op;
   logic [3:0]       alu_result;
   logic             alu_carry;

   // result output handshake
   logic             out_valid;
   logic             out_ready;
   logic [3:0]       out_result;
   logic             out_carry;
   logic             out_zero;
   logic [2:0]       out_op;

   // FIFO occupancy, 0..DEPTH
   logic [CNT_W-1:0] count;

   modport slave (
      input  in_valid,
      input  in_a,
      input  in_b,
      input  in_op,
      output in_ready,
      output alu_a,
      output alu_b,
      output alu_op,
      input  alu_result,
      input  alu_carry,
      output out_valid,
      input  out_ready,
      output out_result,
      output out_carry,
      output out_zero,
      output out_op,
      output count
   );

   modport master (
      output in_valid,
      output in_a,
      output in_b,
      output in_op,
      input  in_ready,
      input  alu_a,
      input  alu_b,
      input  alu_op,
      output alu_result,
      output alu_carry,
      input  out_valid,
      output out_ready,
      input  out_result,
      input  out_carry,
      input  out_zero,
      input  out_op,
      input  count
   );

endinterface : alu_cmd_pipe_if

// File: rtl/alu_cmd_pipe.sv
// -----------------------------------------------------------------------------
// alu_cmd_pipe
//
// Purpose:
//   Command front-end and result stage around an external combinational 4-bit
//   ALU. Commands {op, a, b} are accepted over a valid/ready handshake into a
//   DEPTH-entry FIFO. The FIFO head drives the ALU inputs; the ALU's answer is
//   captured into a single-entry output register with its own valid/ready
//   handshake. Producer and consumer may stall independently.
//
// Ports:
//   clk   : single clock, all state on the rising edge.
//   rst   : synchronous, active-high reset. Clears pointers, count and the
//           whole output stage (valid and data fields).
//   bus   : alu_cmd_pipe_if.slave
//             in_valid/in_ready/in_a/in_b/in_op      command input
//             alu_a/alu_b/alu_op -> alu_result/carry  ALU round trip
//             out_valid/out_ready/out_result/out_carry/out_zero/out_op
//             count                                   FIFO occupancy
//
// Parameters:
//   DEPTH : FIFO entries, power of two, at least 2.
//
// Notes:
//   - No full-bypass: in_ready depends on count alone, so a full FIFO refuses
//     a push even in a cycle where it also pops.
//   - No empty-bypass: the ALU only ever sees registered FIFO contents, so
//     alu_* have no combinational path from in_* or out_ready.
// -----------------------------------------------------------------------------
module alu_cmd_pipe #(
   parameter int DEPTH = 4
) (
   input  logic           clk,
   input  logic           rst,
   alu_cmd_pipe_if.slave  bus
);

   localparam int               PTR_W    = $clog2(DEPTH);
   localparam int               CNT_W    = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   function automatic logic is_zero(input logic [3:0] v);
      return (v == 4'b0000);
   endfunction

   // FIFO storage (data only, never reset: occupancy is tracked by cnt_p0)
   logic [3:0]       a_mem  [DEPTH];
   logic [3:0]       b_mem  [DEPTH];
   logic [2:0]       op_mem [DEPTH];

   logic [PTR_W-1:0] wr_ptr_p0;
   logic [PTR_W-1:0] rd_ptr_p0;
   logic [CNT_W-1:0] cnt_p0;

   logic             empty;
   logic             full;
   logic             push;
   logic             pop;
   logic             out_free;

   // output stage
   logic             vld_p1;
   logic [3:0]       res_p1;
   logic             carry_p1;
   logic             zero_p1;
   logic [2:0]       op_p1;

   assign empty    = (cnt_p0 == '0);
   assign full     = (cnt_p0 == FULL_CNT);
   assign push     = bus.in_valid && !full;
   assign out_free = !vld_p1 || bus.out_ready;
   assign pop      = !empty && out_free;

   // ---------------------------------------------------------------------------
   // stage p0: command FIFO
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (push) begin
         a_mem[wr_ptr_p0]  <= bus.in_a;
         b_mem[wr_ptr_p0]  <= bus.in_b;
         op_mem[wr_ptr_p0] <= bus.in_op;
      end
   end

   // Pointers are exactly log2(DEPTH) bits, so the increment wraps on its own.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_p0 <= '0;
         rd_ptr_p0 <= '0;
         cnt_p0    <= '0;
      end else begin
         if (push) begin
            wr_ptr_p0 <= wr_ptr_p0 + PTR_ONE;
         end
         if (pop) begin
            rd_ptr_p0 <= rd_ptr_p0 + PTR_ONE;
         end
         case ({push, pop})
            2'b10:   cnt_p0 <= cnt_p0 + CNT_ONE;
            2'b01:   cnt_p0 <= cnt_p0 - CNT_ONE;
            default: cnt_p0 <= cnt_p0;
         endcase
      end
   end

   // Head is forced to zero when empty so the ALU never sees stale or
   // uninitialised storage.
   assign bus.alu_a  = empty ? 4'h0 : a_mem[rd_ptr_p0];
   assign bus.alu_b  = empty ? 4'h0 : b_mem[rd_ptr_p0];
   assign bus.alu_op = empty ? 3'h0 : op_mem[rd_ptr_p0];

   // ---------------------------------------------------------------------------
   // stage p1: result register
   // ---------------------------------------------------------------------------
   // A pop always loads, even when the old result is being consumed in the
   // same cycle; clearing valid only happens when nothing replaces it.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1   <= 1'b0;
         res_p1   <= 4'h0;
         carry_p1 <= 1'b0;
         zero_p1  <= 1'b0;
         op_p1    <= 3'h0;
      end else if (pop) begin
         vld_p1   <= 1'b1;
         res_p1   <= bus.alu_result;
         carry_p1 <= bus.alu_carry;
         zero_p1  <= is_zero(bus.alu_result);
         op_p1    <= bus.alu_op;
      end else if (bus.out_ready) begin
         vld_p1   <= 1'b0;
      end
   end

   assign bus.in_ready   = !full;
   assign bus.count      = cnt_p0;
   assign bus.out_valid  = vld_p1;
   assign bus.out_result = res_p1;
   assign bus.out_carry  = carry_p1;
   assign bus.out_zero   = zero_p1;
   assign bus.out_op     = op_p1;

endmodule : alu_cmd_pipe

// File: tb/tb_alu_cmd_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_cmd_pipe
//
// Directed bench for alu_cmd_pipe (DEPTH = 4). A reference 4-bit ALU closes
// the alu_* loop combinationally. Inputs are driven 1 time unit after each
// rising edge and outputs are sampled at that same point, i.e. they show the
// state registered by the preceding edge.
// -----------------------------------------------------------------------------
module tb_alu_cmd_pipe;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;

   typedef struct {
      logic [3:0] r;
      logic       c;
      logic [2:0] op;
   } exp_t;

   exp_t q[$];

   alu_cmd_pipe_if #(.DEPTH(4)) bus ();

   alu_cmd_pipe #(.DEPTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // Reference ALU: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT,
   // 110 SHL, 111 SHR. Carry/borrow only for ADD/SUB. Returns {carry, result}.
   function automatic logic [4:0] ref_alu(input logic [2:0] op,
                                          input logic [3:0] a,
                                          input logic [3:0] b);
      logic [4:0] y;
      case (op)
         3'd0:    y = {1'b0, a} + {1'b0, b};
         3'd1:    y = {(a < b), 4'(a - b)};
         3'd2:    y = {1'b0, a & b};
         3'd3:    y = {1'b0, a | b};
         3'd4:    y = {1'b0, a ^ b};
         3'd5:    y = {1'b0, ~a};
         3'd6:    y = {1'b0, a[2:0], 1'b0};
         default: y = {1'b0, 1'b0, a[3:1]};
      endcase
      return y;
   endfunction

   always_comb begin
      {bus.alu_carry, bus.alu_result} = ref_alu(bus.alu_op, bus.alu_a, bus.alu_b);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [2:0] rop;
      logic [3:0] ra;
      logic [3:0] rb;
      logic [4:0] ry;
      exp_t       e;

      bus.in_valid  = 1'b0;
      bus.in_a      = 4'h0;
      bus.in_b      = 4'h0;
      bus.in_op     = 3'h0;
      bus.out_ready = 1'b0;
      rst           = 1'b1;

      // reset state
      tick();
      tick();
      rst = 1'b0;
      chk("rst_count",      8'(bus.count),      8'd0);
      chk("rst_out_valid",  8'(bus.out_valid),  8'd0);
      chk("rst_out_result", 8'(bus.out_result), 8'd0);
      chk("rst_out_carry",  8'(bus.out_carry),  8'd0);
      chk("rst_out_zero",   8'(bus.out_zero),   8'd0);
      chk("rst_out_op",     8'(bus.out_op),     8'd0);
      chk("rst_in_ready",   8'(bus.in_ready),   8'd1);
      chk("rst_alu_a",      8'(bus.alu_a),      8'd0);

      // single ADD 9 + 8 = 0x11
      bus.out_ready = 1'b1;
      bus.in_valid = 1'b1; bus.in_op = 3'd0; bus.in_a = 4'h9; bus.in_b = 4'h8;
      tick();
      bus.in_valid = 1'b0;
      chk("add_count_head", 8'(bus.count),      8'd1);
      chk("add_head_a",     8'(bus.alu_a),      8'h9);
      chk("add_not_yet",    8'(bus.out_valid),  8'd0);
      tick();
      chk("add_valid",      8'(bus.out_valid),  8'd1);
      chk("add_result",     8'(bus.out_result), 8'h1);
      chk("add_carry",      8'(bus.out_carry),  8'd1);
      chk("add_zero",       8'(bus.out_zero),   8'd0);
      chk("add_op",         8'(bus.out_op),     8'd0);
      chk("add_count",      8'(bus.count),      8'd0);
      tick();
      chk("add_once",       8'(bus.out_valid),  8'd0);

      // SUB 5 - 5 = 0 (zero flag)
      bus.in_valid = 1'b1; bus.in_op = 3'd1; bus.in_a = 4'h5; bus.in_b = 4'h5;
      tick();
      bus.in_valid = 1'b0;
      tick();
      chk("sub0_valid",     8'(bus.out_valid),  8'd1);
      chk("sub0_result",    8'(bus.out_result), 8'h0);
      chk("sub0_zero",      8'(bus.out_zero),   8'd1);
      chk("sub0_carry",     8'(bus.out_carry),  8'd0);
      tick();

      // SUB 3 - 4 = 0xF with borrow
      bus.in_valid = 1'b1; bus.in_op = 3'd1; bus.in_a = 4'h3; bus.in_b = 4'h4;
      tick();
      bus.in_valid = 1'b0;
      tick();
      chk("sub_b_result",   8'(bus.out_result), 8'hF);
      chk("sub_b_carry",    8'(bus.out_carry),  8'd1);
      chk("sub_b_zero",     8'(bus.out_zero),   8'd0);
      chk("sub_b_op",       8'(bus.out_op),     8'd1);
      tick();
      chk("sub_b_once",     8'(bus.out_valid),  8'd0);

      // back-pressure fill: ops 010..110 with a=A, b=6, consumer stalled
      bus.out_ready = 1'b0;
      for (int k = 2; k <= 6; k++) begin
         bus.in_valid = 1'b1; bus.in_op = 3'(k); bus.in_a = 4'hA; bus.in_b = 4'h6;
         tick();
      end
      bus.in_op = 3'd7;
      chk("bp_count",       8'(bus.count),      8'd4);
      chk("bp_in_ready",    8'(bus.in_ready),   8'd0);
      chk("bp_valid",       8'(bus.out_valid),  8'd1);
      chk("bp_result",      8'(bus.out_result), 8'h2);
      chk("bp_op",          8'(bus.out_op),     8'd2);
      chk("bp_head_op",     8'(bus.alu_op),     8'd3);
      tick();
      chk("bp_stall_count", 8'(bus.count),      8'd4);
      chk("bp_stall_res",   8'(bus.out_result), 8'h2);
      chk("bp_stall_head",  8'(bus.alu_op),     8'd3);

      // full: one-cycle out_ready pulse pops but refuses the pending push
      bus.out_ready = 1'b1;
      chk("full_in_ready",  8'(bus.in_ready),   8'd0);
      tick();
      bus.out_ready = 1'b0;
      chk("pulse_count",    8'(bus.count),      8'd3);
      chk("pulse_in_ready", 8'(bus.in_ready),   8'd1);
      chk("pulse_result",   8'(bus.out_result), 8'hE);
      chk("pulse_op",       8'(bus.out_op),     8'd3);
      tick();
      chk("late_push_cnt",  8'(bus.count),      8'd4);
      chk("late_hold_res",  8'(bus.out_result), 8'hE);
      chk("late_in_ready",  8'(bus.in_ready),   8'd0);

      // release and drain: XOR=C, NOT=5, SHL=4, SHR=5
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b0;
      tick();
      chk("drain_xor_res",  8'(bus.out_result), 8'hC);
      chk("drain_xor_op",   8'(bus.out_op),     8'd4);
      chk("drain_xor_cnt",  8'(bus.count),      8'd3);
      tick();
      chk("drain_not_res",  8'(bus.out_result), 8'h5);
      chk("drain_not_op",   8'(bus.out_op),     8'd5);
      tick();
      chk("drain_shl_res",  8'(bus.out_result), 8'h4);
      chk("drain_shl_cy",   8'(bus.out_carry),  8'd0);
      chk("drain_shl_op",   8'(bus.out_op),     8'd6);
      tick();
      chk("drain_shr_res",  8'(bus.out_result), 8'h5);
      chk("drain_shr_op",   8'(bus.out_op),     8'd7);
      chk("drain_shr_vld",  8'(bus.out_valid),  8'd1);
      chk("drain_cnt0",     8'(bus.count),      8'd0);
      tick();
      chk("drain_done",     8'(bus.out_valid),  8'd0);

      // steady-state simultaneous push/pop with random commands
      for (int i = 0; i < 20; i++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = 4'($urandom);
         rb  = 4'($urandom);
         bus.in_valid = 1'b1; bus.in_op = rop; bus.in_a = ra; bus.in_b = rb;
         chk("rnd_in_ready", 8'(bus.in_ready), 8'd1);
         ry   = ref_alu(rop, ra, rb);
         e.r  = ry[3:0];
         e.c  = ry[4];
         e.op = rop;
         q.push_back(e);
         tick();
         chk("rnd_out_valid", 8'(bus.out_valid), (i >= 1) ? 8'd1 : 8'd0);
         if (i >= 1) chk("rnd_count", 8'(bus.count), 8'd1);
         if (bus.out_valid && q.size() > 0) begin
            e = q.pop_front();
            chk("rnd_result", 8'(bus.out_result), 8'(e.r));
            chk("rnd_carry",  8'(bus.out_carry),  8'(e.c));
            chk("rnd_op",     8'(bus.out_op),     8'(e.op));
         end
      end
      bus.in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (bus.out_valid) begin
            if (q.size() != 0) begin
               e = q.pop_front();
               chk("rnd_tail_result", 8'(bus.out_result), 8'(e.r));
               chk("rnd_tail_op",     8'(bus.out_op),     8'(e.op));
            end else begin
               chk("rnd_duplicate", 8'(bus.out_valid), 8'd0);
            end
         end
      end
      chk("rnd_drained", 8'(q.size()), 8'd0);

      // mid-stream reset with buffered commands and a held result
      bus.out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         bus.in_valid = 1'b1; bus.in_op = 3'd0; bus.in_a = 4'h7; bus.in_b = 4'h7;
         tick();
      end
      bus.in_valid = 1'b0;
      chk("mr_pre_count",   8'(bus.count),      8'd3);
      chk("mr_pre_valid",   8'(bus.out_valid),  8'd1);
      chk("mr_pre_result",  8'(bus.out_result), 8'hE);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mr_valid",       8'(bus.out_valid),  8'd0);
      chk("mr_count",       8'(bus.count),      8'd0);
      chk("mr_result",      8'(bus.out_result), 8'd0);
      chk("mr_in_ready",    8'(bus.in_ready),   8'd1);
      chk("mr_alu_a",       8'(bus.alu_a),      8'd0);
      bus.out_ready = 1'b1;
      tick();
      tick();
      chk("mr_no_stale",    8'(bus.out_valid),  8'd0);
      bus.in_valid = 1'b1; bus.in_op = 3'd0; bus.in_a = 4'h1; bus.in_b = 4'h2;
      tick();
      bus.in_valid = 1'b0;
      tick();
      chk("mr_fresh_valid", 8'(bus.out_valid),  8'd1);
      chk("mr_fresh_res",   8'(bus.out_result), 8'h3);
      chk("mr_fresh_count", 8'(bus.count),      8'd0);
      tick();
      chk("mr_fresh_once",  8'(bus.out_valid),  8'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_alu_cmd_pipe

// File: doc/alu_cmd_pipe.md
# alu_cmd_pipe

Command front-end and result stage wrapped around the 4-bit ALU. It accepts ALU commands (op, a, b) over a valid/ready handshake and buffers them in a DEPTH-entry FIFO. It presents the FIFO head to the ALU's combinational inputs, then registers the ALU's result and carry into a single-entry output stage with its own valid/ready handshake. It lets a producer and consumer with independent stall behaviour share one combinational ALU.

## Interface
- DEPTH, default 4: FIFO entries; power of two, at least 2.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  command available.
- in_ready  out  1  FIFO can accept; equals (count != DEPTH).
- in_a  in  4  operand A.
- in_b  in  4  operand B.
- in_op  in  3  ALU op code; ALU encoding, 000 ADD through 111 SHR.
- alu_a  out  4  FIFO head operand A; 0 when FIFO empty.
- alu_b  out  4  FIFO head operand B; 0 when empty.
- alu_op  out  3  FIFO head op; 0 when empty.
- alu_result  in  4  ALU result for alu_a/alu_b/alu_op.
- alu_carry  in  1  ALU carry/borrow.
- out_valid  out  1  output stage holds a result.
- out_ready  in  1  consumer accepts the result.
- out_result  out  4  registered result.
- out_carry  out  1  registered carry.
- out_zero  out  1  1 when out_result == 0.
- out_op  out  3  op that produced the result.
- count  out  log2(DEPTH)+1  FIFO occupancy, 0..DEPTH.

## Operation
- push = in_valid && in_ready. Write {op, a, b} at the write pointer and advance the pointer modulo DEPTH.
- out_free = !out_valid || out_ready.
- pop = (count != 0) && out_free. Advance the read pointer modulo DEPTH. Load the output stage with alu_result, alu_carry, (alu_result == 4'b0) and alu_op. Set out_valid = 1.
- If out_ready && out_valid && no pop, clear out_valid. Data fields hold their last value.
- count_next = count + push - pop. Simultaneous push and pop leaves count unchanged.
- When full, in_ready = 0, even if a pop occurs the same cycle; there is no full-bypass.
- When empty, there is no empty-bypass: a command pushed this cycle cannot pop this cycle.
- The block pipes alu_carry through unmodified for every op. The ALU drives 0 for ops other than 000/001.
- in_a/in_b/in_op are don't-care when in_valid = 0. The block never writes the FIFO without push.
- Ordering is strict FIFO: results leave in command-acceptance order, with no drops and no duplicates.

## Timing
- Reset, when rst is high at a clock edge:
  - count = 0 and both pointers = 0.
  - out_valid = 0, out_result = 0, out_carry = 0, out_zero = 0, out_op = 0.
  - in_ready = 1 from the cycle after reset.
- Reset mid-operation discards all buffered commands and any held result. The pending out_valid drops on that edge.
- Latency: a command handshaked in cycle k is at the FIFO head in cycle k+1. With out_free in cycle k+1, out_valid = 1 in cycle k+2 with its result.
- Throughput: one command per cycle sustained when out_ready is held at 1.
- Output stall: while out_valid && !out_ready, no pop occurs. The output fields and the FIFO head are stable, and the FIFO fills. Once count reaches DEPTH, in_ready goes low the next cycle.
- alu_a/alu_b/alu_op are combinational from the registered head and pointers only, with no path from in_* or out_ready.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. Full/empty are derived from count only.

## Test plan
- Reset then single ADD: push op=000, a=4'h9, b=4'h8 with out_ready=1 -> 2 cycles later out_valid=1, out_result=4'h1, out_carry=1, out_zero=0, out_op=000, for exactly one cycle.
- SUB zero flag: push op=001, a=5, b=5 -> out_result=0, out_zero=1, out_carry=0. Then push op=001, a=3, b=4 -> out_result=4'hF, out_carry=1 (borrow).
- Back-pressure fill: hold out_ready=0 and push 6 commands (ops 010..111, a=4'hA, b=4'h6) -> out_valid is held on the first result, count reaches 4 with 1 in the output stage, and in_ready=0. Release out_ready -> results AND=2, OR=E, XOR=C, NOT=5, SHL=4, SHR=5 emerge in order, once each.
- Simultaneous push/pop at steady state: in_valid=1 and out_ready=1 for 20 random commands -> count stays constant after fill, and each output matches a reference ALU model in order.
- Full with out_ready toggling: with count=DEPTH and in_valid=1, pulse out_ready -> the pop occurs, no push is accepted that cycle, and the push is accepted the next cycle when in_ready=1.
- Mid-stream reset: with 3 buffered commands and out_valid=1, assert rst for 1 cycle -> out_valid=0, count=0, out_result=0 on that edge, and no stale results appear afterwards.
